// File: rtl/ctrl_tag_allocator.sv
// Branch checkpoint tag allocator: hands out free-list tags to the control
// instructions of each dispatch bundle and reclaims them on resolve or flush.
module ctrl_tag_allocator #(
  parameter int BRANCH_TAGS    = 8,
  parameter int TAG_LOG        = 3,
  parameter int DISPATCH_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      instBufferReady_i,
  input  logic                      stall_i,
  input  logic [DISPATCH_WIDTH-1:0] branchVector_i,
  input  logic [TAG_LOG-1:0]        branchCount_i,
  input  logic                      resolveValid_i,
  input  logic [TAG_LOG-1:0]        resolveTag_i,
  output logic                      stallBranch_o,
  output logic                      bundleValid_o,
  output logic [DISPATCH_WIDTH-1:0] tagValid_o,
  output logic [TAG_LOG-1:0]        tag0_o,
  output logic [TAG_LOG-1:0]        tag1_o,
  output logic [TAG_LOG-1:0]        tag2_o,
  output logic [TAG_LOG-1:0]        tag3_o,
  output logic [TAG_LOG:0]          freeCount_o,
  output logic                      error_o
);

  logic [BRANCH_TAGS-1:0] free_map;
  logic [BRANCH_TAGS-1:0] avail;
  logic [BRANCH_TAGS-1:0] alloc_mask;
  logic [BRANCH_TAGS-1:0] release_mask;
  logic [BRANCH_TAGS-1:0] free_map_next;
  logic [TAG_LOG:0]       free_count_next;
  logic [TAG_LOG:0]       vec_count;
  logic [TAG_LOG-1:0]     slot_tag [DISPATCH_WIDTH];
  logic [TAG_LOG-1:0]     tag_q    [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0] slot_valid;
  logic                   fire;
  logic                   release_err;
  logic                   count_err;

  assign stallBranch_o = instBufferReady_i && (freeCount_o < {1'b0, branchCount_i});
  assign fire          = instBufferReady_i && !stall_i && !stallBranch_o;

  // Each branch slot takes the lowest free tag left over by earlier slots.
  always_comb begin
    avail      = free_map;
    slot_valid = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      slot_tag[k] = '0;
      if (branchVector_i[k] && (|avail)) begin
        slot_valid[k] = 1'b1;
        for (int t = BRANCH_TAGS - 1; t >= 0; t--) begin
          if (avail[t]) slot_tag[k] = TAG_LOG'(t);
        end
        avail[slot_tag[k]] = 1'b0;
      end
    end
  end

  always_comb begin
    vec_count = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      vec_count = vec_count + (TAG_LOG + 1)'(branchVector_i[k]);
    end
  end

  assign alloc_mask    = fire ? (free_map & ~avail) : '0;
  assign release_mask  = resolveValid_i ? (BRANCH_TAGS'(1) << resolveTag_i) : '0;
  // Release ORs in after allocation so a same-cycle alloc+release of one tag ends free.
  assign free_map_next = (free_map & ~alloc_mask) | release_mask;

  always_comb begin
    free_count_next = '0;
    for (int t = 0; t < BRANCH_TAGS; t++) begin
      free_count_next = free_count_next + (TAG_LOG + 1)'(free_map_next[t]);
    end
  end

  assign release_err = resolveValid_i && !flush_i && free_map[resolveTag_i]
                       && !alloc_mask[resolveTag_i];
  assign count_err   = instBufferReady_i && (vec_count != {1'b0, branchCount_i});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_map      <= '1;
      freeCount_o   <= (TAG_LOG + 1)'(BRANCH_TAGS);
      bundleValid_o <= 1'b0;
      tagValid_o    <= '0;
      error_o       <= 1'b0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) tag_q[k] <= '0;
    end else begin
      error_o <= error_o | release_err | count_err;
      if (flush_i) begin
        free_map      <= '1;
        freeCount_o   <= (TAG_LOG + 1)'(BRANCH_TAGS);
        bundleValid_o <= 1'b0;
        tagValid_o    <= '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) tag_q[k] <= '0;
      end else begin
        free_map    <= free_map_next;
        freeCount_o <= free_count_next;
        if (fire) begin
          bundleValid_o <= 1'b1;
          tagValid_o    <= slot_valid;
          for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            tag_q[k] <= slot_valid[k] ? slot_tag[k] : '0;
          end
        end else begin
          bundleValid_o <= 1'b0;
          tagValid_o    <= '0;
        end
      end
    end
  end

  assign tag0_o = tag_q[0];
  assign tag1_o = tag_q[1];
  assign tag2_o = tag_q[2];
  assign tag3_o = tag_q[3];

endmodule

// File: tb/tb_ctrl_tag_allocator.sv
// Scoreboard bench for ctrl_tag_allocator: directed bundles push expected
// tag sets; a negedge monitor pops and compares whenever bundleValid_o rises.
module tb_ctrl_tag_allocator;

  logic       clk;
  logic       reset;
  logic       flush_i;
  logic       instBufferReady_i;
  logic       stall_i;
  logic [3:0] branchVector_i;
  logic [2:0] branchCount_i;
  logic       resolveValid_i;
  logic [2:0] resolveTag_i;
  logic       stallBranch_o;
  logic       bundleValid_o;
  logic [3:0] tagValid_o;
  logic [2:0] tag0_o, tag1_o, tag2_o, tag3_o;
  logic [3:0] freeCount_o;
  logic       error_o;

  typedef struct packed {
    logic [3:0] tv;
    logic [2:0] t0, t1, t2, t3;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  ctrl_tag_allocator dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .instBufferReady_i(instBufferReady_i), .stall_i(stall_i),
    .branchVector_i(branchVector_i), .branchCount_i(branchCount_i),
    .resolveValid_i(resolveValid_i), .resolveTag_i(resolveTag_i),
    .stallBranch_o(stallBranch_o), .bundleValid_o(bundleValid_o),
    .tagValid_o(tagValid_o), .tag0_o(tag0_o), .tag1_o(tag1_o),
    .tag2_o(tag2_o), .tag3_o(tag3_o), .freeCount_o(freeCount_o),
    .error_o(error_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && bundleValid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bundle: got tagValid=%b expected no bundle", tagValid_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bundle_tagValid", int'(tagValid_o), int'(e.tv));
        check("bundle_tag0", int'(tag0_o), int'(e.t0));
        check("bundle_tag1", int'(tag1_o), int'(e.t1));
        check("bundle_tag2", int'(tag2_o), int'(e.t2));
        check("bundle_tag3", int'(tag3_o), int'(e.t3));
        check("bundle_freeCount", int'(freeCount_o), int'(e.fc));
      end
    end
  end

  task automatic idle();
    flush_i = 1'b0; instBufferReady_i = 1'b0; stall_i = 1'b0;
    branchVector_i = '0; branchCount_i = '0;
    resolveValid_i = 1'b0; resolveTag_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] vec, input logic [2:0] cnt,
                       input logic rv, input logic [2:0] rt,
                       input logic [3:0] etv, input logic [2:0] e0, e1, e2, e3,
                       input logic [3:0] efc);
    exp_t e;
    instBufferReady_i = 1'b1; stall_i = 1'b0;
    branchVector_i = vec; branchCount_i = cnt;
    resolveValid_i = rv; resolveTag_i = rt;
    #1;
    check("stall_on_issue", int'(stallBranch_o), 0);
    e.tv = etv; e.t0 = e0; e.t1 = e1; e.t2 = e2; e.t3 = e3; e.fc = efc;
    exp_q.push_back(e);
    tick();
    idle();
  endtask

  task automatic release_tag(input logic [2:0] t);
    resolveValid_i = 1'b1; resolveTag_i = t;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bundleValid", int'(bundleValid_o), 0);
    check("reset_tagValid", int'(tagValid_o), 0);
    check("reset_tag3", int'(tag3_o), 0);
    check("reset_freeCount", int'(freeCount_o), 8);
    check("reset_error", int'(error_o), 0);
    check("reset_stall", int'(stallBranch_o), 0);
    reset = 1'b1;
    mon_en = 1'b1;
    tick();

    // Sparse bundle
    issue(4'b1010, 3'd2, 1'b0, 3'd0, 4'b1010, 3'd0, 3'd0, 3'd0, 3'd1, 4'd6);
    flush_i = 1'b1; tick(); idle();
    check("flush_freeCount", int'(freeCount_o), 8);

    // Exhaust all tags, then a full bundle stalls
    issue(4'b1111, 3'd4, 1'b0, 3'd0, 4'b1111, 3'd0, 3'd1, 3'd2, 3'd3, 4'd4);
    issue(4'b1111, 3'd4, 1'b0, 3'd0, 4'b1111, 3'd4, 3'd5, 3'd6, 3'd7, 4'd0);
    instBufferReady_i = 1'b1; branchVector_i = 4'b1111; branchCount_i = 3'd4;
    #1 check("exhausted_stall", int'(stallBranch_o), 1);
    tick();
    check("exhausted_no_bundle", int'(bundleValid_o), 0);
    check("exhausted_freeCount", int'(freeCount_o), 0);

    // Release 5 while a 1-branch bundle waits: no same-cycle bypass
    branchVector_i = 4'b0001; branchCount_i = 3'd1;
    resolveValid_i = 1'b1; resolveTag_i = 3'd5;
    #1 check("release_no_bypass_stall", int'(stallBranch_o), 1);
    tick(); idle();
    check("release_freeCount", int'(freeCount_o), 1);
    issue(4'b0001, 3'd1, 1'b0, 3'd0, 4'b0001, 3'd5, 3'd0, 3'd0, 3'd0, 4'd0);
    issue(4'b0000, 3'd0, 1'b0, 3'd0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0);

    // Downstream stall holds the bundle
    for (int t = 0; t < 4; t++) release_tag(3'(t));
    check("released4_freeCount", int'(freeCount_o), 4);
    instBufferReady_i = 1'b1; stall_i = 1'b1;
    branchVector_i = 4'b0110; branchCount_i = 3'd2;
    #1 check("stall_i_branch_stall", int'(stallBranch_o), 0);
    tick();
    check("stall_i_no_bundle", int'(bundleValid_o), 0);
    check("stall_i_freeCount", int'(freeCount_o), 4);
    issue(4'b0110, 3'd2, 1'b0, 3'd0, 4'b0110, 3'd0, 3'd0, 3'd1, 3'd0, 4'd2);

    // Flush overrides simultaneous fire and release (6 tags out)
    flush_i = 1'b1; instBufferReady_i = 1'b1;
    branchVector_i = 4'b0001; branchCount_i = 3'd1;
    resolveValid_i = 1'b1; resolveTag_i = 3'd4;
    tick(); idle();
    check("flush_fire_freeCount", int'(freeCount_o), 8);
    check("flush_fire_bundleValid", int'(bundleValid_o), 0);
    check("flush_fire_tagValid", int'(tagValid_o), 0);
    check("flush_fire_tag2", int'(tag2_o), 0);

    // Same-cycle alloc+release of one tag, then of different tags
    issue(4'b0011, 3'd2, 1'b1, 3'd0, 4'b0011, 3'd0, 3'd1, 3'd0, 3'd0, 4'd7);
    check("alloc_release_same_no_error", int'(error_o), 0);
    issue(4'b0001, 3'd1, 1'b1, 3'd1, 4'b0001, 3'd0, 3'd0, 3'd0, 3'd0, 4'd7);
    check("alloc_release_diff_no_error", int'(error_o), 0);

    // Error on double release, sticky through flush, cleared by reset
    release_tag(3'd2);
    check("double_release_error", int'(error_o), 1);
    flush_i = 1'b1; tick(); idle();
    check("error_survives_flush", int'(error_o), 1);
    reset = 1'b0; #1;
    check("reset_clears_error", int'(error_o), 0);
    check("reset_freeCount_again", int'(freeCount_o), 8);
    reset = 1'b1;
    tick();

    // Count/vector mismatch: allocation follows the vector
    issue(4'b0001, 3'd3, 1'b0, 3'd0, 4'b0001, 3'd0, 3'd0, 3'd0, 3'd0, 4'd7);
    check("mismatch_error", int'(error_o), 1);

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
